// File: rtl/mux_stream_n.sv
// mux_stream_n: N-channel registered stream multiplexer with external or round-robin select
module mux_stream_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    err_sel
);
  logic [SEL_W-1:0]  ptr, gnt_idx;
  logic [SEL_W:0]    sum;
  logic [NUM_CH-1:0] rot;
  logic [WIDTH-1:0]  gnt_data;
  logic              gnt_any, space, load, sel_bad;
  assign space   = !out_valid || out_ready;
  assign load    = gnt_any && space && rst_n;
  assign sel_bad = {1'b0, sel} >= (SEL_W+1)'(NUM_CH);
  assign rot     = NUM_CH'({in_valid, in_valid} >> ptr);
  // grant: external select, or first valid channel at or after ptr (rot is in_valid rotated so ptr sits at bit 0)
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    if (MODE == 0) begin
      gnt_idx = sel;
      for (int i = 0; i < NUM_CH; i++)
        if (SEL_W'(i) == sel && in_valid[i]) gnt_any = 1'b1;
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--)
        if (rot[k]) begin
          gnt_any = 1'b1;
          sum     = {1'b0, ptr} + (SEL_W+1)'(k);
          gnt_idx = SEL_W'(sum >= (SEL_W+1)'(NUM_CH) ? sum - (SEL_W+1)'(NUM_CH) : sum);
        end
    end
  end
  // route the granted word and raise only the granted channel's ready
  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (SEL_W'(i) == gnt_idx) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load;
      end
  end
  // output register, sticky select error and round-robin pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      err_sel   <= 1'b0;
      ptr       <= '0;
    end else begin
      if (load) begin
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      if (MODE == 0 && sel_bad && |in_valid) err_sel <= 1'b1;
      if (MODE == 1 && load) ptr <= gnt_idx == SEL_W'(NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end
endmodule

// File: tb/tb_mux_stream_n.sv
// tb_mux_stream_n: checks select, round-robin and out-of-range variants against a reference model
module tb_mux_stream_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] a_data = '0;
  logic [3:0]   a_valid = '0, a_ready;
  logic [1:0]   a_sel = '0, a_och;
  logic [31:0]  a_odata;
  logic         a_ovalid, a_oready = 1'b0, a_err;

  logic [127:0] b_data = '0;
  logic [3:0]   b_valid = '0, b_ready;
  logic [1:0]   b_sel = '0, b_och;
  logic [31:0]  b_odata;
  logic         b_ovalid, b_oready = 1'b0, b_err;

  logic [95:0]  c_data = '0;
  logic [2:0]   c_valid = '0, c_ready;
  logic [1:0]   c_sel = '0, c_och;
  logic [31:0]  c_odata;
  logic         c_ovalid, c_oready = 1'b0, c_err;

  always #5 clk = ~clk;

  mux_stream_n #(.WIDTH(32), .NUM_CH(4), .SEL_W(2), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .sel(a_sel), .out_data(a_odata), .out_valid(a_ovalid), .out_ready(a_oready),
    .out_ch(a_och), .err_sel(a_err));

  mux_stream_n #(.WIDTH(32), .NUM_CH(4), .SEL_W(2), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .sel(b_sel), .out_data(b_odata), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_ch(b_och), .err_sel(b_err));

  mux_stream_n #(.WIDTH(32), .NUM_CH(3), .SEL_W(2), .MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .sel(c_sel), .out_data(c_odata), .out_valid(c_ovalid), .out_ready(c_oready),
    .out_ch(c_och), .err_sel(c_err));

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 4'hF;
    b_valid = 4'hF;
    c_valid = 3'h7;
    #1;
    n_cmp++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL reset_ovalid: got %b expected 0", a_ovalid); end
    n_cmp++; if (a_odata !== 32'h0) begin n_err++; $display("FAIL reset_odata: got %h expected 0", a_odata); end
    n_cmp++; if (a_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready_a: got %b expected 0000", a_ready); end
    n_cmp++; if (b_ready !== 4'h0) begin n_err++; $display("FAIL reset_ready_b: got %b expected 0000", b_ready); end
    n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", a_err); end
    @(negedge clk);
    rst_n = 1'b1;
    a_valid = '0;
    b_valid = '0;
    c_valid = '0;
    repeat (2) begin
      @(posedge clk); #1;
      n_cmp++; if (a_ovalid !== 1'b0 || b_ovalid !== 1'b0) begin n_err++; $display("FAIL idle_ovalid: got %b%b expected 00", a_ovalid, b_ovalid); end
      n_cmp++; if (a_odata !== 32'h0) begin n_err++; $display("FAIL idle_odata: got %h expected 0", a_odata); end
    end
  endtask

  task automatic test_select();
    @(negedge clk);
    a_sel = 2'd2;
    a_data[64 +: 32] = 32'hDEADBEEF;
    a_valid = 4'b0100;
    a_oready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 4'b0100) begin n_err++; $display("FAIL sel_ready: got %b expected 0100", a_ready); end
    @(posedge clk); #1;
    n_cmp++; if (a_ovalid !== 1'b1) begin n_err++; $display("FAIL sel_ovalid: got %b expected 1", a_ovalid); end
    n_cmp++; if (a_odata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sel_odata: got %h expected deadbeef", a_odata); end
    n_cmp++; if (a_och !== 2'd2) begin n_err++; $display("FAIL sel_och: got %0d expected 2", a_och); end
    @(negedge clk);
    a_valid = '0;
    @(posedge clk); #1;
    n_cmp++; if (a_ovalid !== 1'b0) begin n_err++; $display("FAIL drain_ovalid: got %b expected 0", a_ovalid); end
    n_cmp++; if (a_odata !== 32'hDEADBEEF) begin n_err++; $display("FAIL drain_hold: got %h expected deadbeef", a_odata); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_sel = 2'd0;
    a_data[0 +: 32] = 32'h11111111;
    a_valid = 4'b0001;
    a_oready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (a_odata !== 32'h11111111) begin n_err++; $display("FAIL bp_first: got %h expected 11111111", a_odata); end
    @(negedge clk);
    a_oready = 1'b0;
    a_sel = 2'd1;
    a_data[32 +: 32] = 32'h22222222;
    a_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (a_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, a_ready); end
      @(posedge clk); #1;
      n_cmp++; if (a_odata !== 32'h11111111 || a_ovalid !== 1'b1 || a_och !== 2'd0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %h/%b/%0d expected 11111111/1/0", i, a_odata, a_ovalid, a_och);
      end
      @(negedge clk);
    end
    a_oready = 1'b1;
    #1;
    n_cmp++; if (a_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release_ready: got %b expected 0010", a_ready); end
    @(posedge clk); #1;
    n_cmp++; if (a_odata !== 32'h22222222 || a_och !== 2'd1) begin n_err++; $display("FAIL bp_second: got %h/%0d expected 22222222/1", a_odata, a_och); end
    @(negedge clk);
    a_valid = '0;
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    for (int i = 0; i < 4; i++) b_data[i*32 +: 32] = 32'hA0 + 32'(i);
    b_valid = 4'hF;
    b_oready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (b_och !== 2'(i % 4)) begin n_err++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", i, b_och, i % 4); end
      n_cmp++; if (b_odata !== 32'hA0 + 32'(i % 4)) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", i, b_odata, 32'hA0 + 32'(i % 4)); end
    end
    @(negedge clk);
    b_valid = 4'b1010;
    #1;
    n_cmp++; if (b_ready !== 4'b1000) begin n_err++; $display("FAIL rr_skip_ready: got %b expected 1000", b_ready); end
    @(posedge clk); #1;
    n_cmp++; if (b_och !== 2'd3) begin n_err++; $display("FAIL rr_skip_ch: got %0d expected 3", b_och); end
    @(posedge clk); #1;
    n_cmp++; if (b_och !== 2'd1) begin n_err++; $display("FAIL rr_wrap_ch: got %0d expected 1", b_och); end
    @(negedge clk);
    b_valid = '0;
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    c_data = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    c_sel = 2'd3;
    c_valid = 3'b111;
    c_oready = 1'b1;
    #1;
    n_cmp++; if (c_ready !== 3'b000) begin n_err++; $display("FAIL oor_ready: got %b expected 000", c_ready); end
    @(posedge clk); #1;
    n_cmp++; if (c_err !== 1'b1) begin n_err++; $display("FAIL oor_err: got %b expected 1", c_err); end
    n_cmp++; if (c_ovalid !== 1'b0) begin n_err++; $display("FAIL oor_ovalid: got %b expected 0", c_ovalid); end
    @(negedge clk);
    c_sel = 2'd0;
    #1;
    n_cmp++; if (c_ready !== 3'b001) begin n_err++; $display("FAIL oor_recover_ready: got %b expected 001", c_ready); end
    @(posedge clk); #1;
    n_cmp++; if (c_err !== 1'b1) begin n_err++; $display("FAIL oor_sticky: got %b expected 1", c_err); end
    n_cmp++; if (c_odata !== 32'hC0C0C0C0 || c_ovalid !== 1'b1) begin n_err++; $display("FAIL oor_recover_data: got %h/%b expected c0c0c0c0/1", c_odata, c_ovalid); end
    @(negedge clk);
    c_valid = '0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    b_valid = 4'b0100;
    b_oready = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (b_ovalid !== 1'b1 || b_och !== 2'd2) begin n_err++; $display("FAIL mid_load: got %b/%0d expected 1/2", b_ovalid, b_och); end
    @(negedge clk);
    b_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (b_ovalid !== 1'b0) begin n_err++; $display("FAIL mid_async_ovalid: got %b expected 0", b_ovalid); end
    n_cmp++; if (c_err !== 1'b0) begin n_err++; $display("FAIL mid_err_clear: got %b expected 0", c_err); end
    @(negedge clk);
    rst_n = 1'b1;
    b_valid = 4'hF;
    b_oready = 1'b1;
    #1;
    n_cmp++; if (b_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_ready: got %b expected 0001", b_ready); end
    @(posedge clk); #1;
    n_cmp++; if (b_och !== 2'd0 || b_ovalid !== 1'b1) begin n_err++; $display("FAIL mid_first_ch: got %0d/%b expected 0/1", b_och, b_ovalid); end
    @(negedge clk);
    b_valid = '0;
  endtask

  task automatic test_random();
    logic        ea_v, eb_v;
    logic [31:0] ea_d, eb_d;
    logic [1:0]  ea_c, eb_c, eb_p;
    logic [3:0]  er;
    int          ga, gb, idx;
    @(negedge clk);
    a_valid = '0;
    b_valid = '0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    ea_v = 1'b0; ea_d = '0; ea_c = '0;
    eb_v = 1'b0; eb_d = '0; eb_c = '0; eb_p = '0;
    repeat (300) begin
      @(negedge clk);
      a_data = {$urandom, $urandom, $urandom, $urandom};
      b_data = {$urandom, $urandom, $urandom, $urandom};
      a_valid = 4'($urandom);
      b_valid = 4'($urandom);
      a_sel = 2'($urandom_range(0, 3));
      a_oready = $urandom_range(0, 3) != 0;
      b_oready = $urandom_range(0, 3) != 0;
      #1;
      ga = (a_valid[a_sel] && (!ea_v || a_oready)) ? int'(a_sel) : -1;
      gb = -1;
      if (!eb_v || b_oready)
        for (int k = 0; k < 4; k++) begin
          idx = (int'(eb_p) + k) % 4;
          if (gb < 0 && b_valid[idx]) gb = idx;
        end
      er = ga >= 0 ? 4'b0001 << ga : 4'b0000;
      n_cmp++; if (a_ready !== er) begin n_err++; $display("FAIL rnd_ready_a: got %b expected %b", a_ready, er); end
      er = gb >= 0 ? 4'b0001 << gb : 4'b0000;
      n_cmp++; if (b_ready !== er) begin n_err++; $display("FAIL rnd_ready_b: got %b expected %b", b_ready, er); end
      @(posedge clk); #1;
      if (ga >= 0) begin
        ea_v = 1'b1; ea_d = a_data[ga*32 +: 32]; ea_c = 2'(ga);
      end else if (a_oready) ea_v = 1'b0;
      if (gb >= 0) begin
        eb_v = 1'b1; eb_d = b_data[gb*32 +: 32]; eb_c = 2'(gb); eb_p = 2'((gb + 1) % 4);
      end else if (b_oready) eb_v = 1'b0;
      n_cmp++; if (a_ovalid !== ea_v || a_odata !== ea_d || a_och !== ea_c) begin
        n_err++; $display("FAIL rnd_out_a: got %b/%h/%0d expected %b/%h/%0d", a_ovalid, a_odata, a_och, ea_v, ea_d, ea_c);
      end
      n_cmp++; if (b_ovalid !== eb_v || b_odata !== eb_d || b_och !== eb_c) begin
        n_err++; $display("FAIL rnd_out_b: got %b/%h/%0d expected %b/%h/%0d", b_ovalid, b_odata, b_och, eb_v, eb_d, eb_c);
      end
    end
    n_cmp++; if (a_err !== 1'b0 || b_err !== 1'b0) begin n_err++; $display("FAIL rnd_err: got %b%b expected 00", a_err, b_err); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_round_robin();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mux_stream_n.md
Name: mux_stream_n

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output; successor to the fixed 32-bit 2:1 datapath select.
- Channel is picked by an external select (MODE=0) or by a round-robin arbiter (MODE=1). The winning word is captured into a one-entry output register.
- Used in the CPU datapath wherever several producers (ALU, memory, immediate, PC+4 paths) feed one consumer that can stall.

Parameters:
- WIDTH, 32, data width per channel.
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must satisfy 2^SEL_W >= NUM_CH.
- MODE, 0, 0 = external select, 1 = round-robin arbitration (sel ignored).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- sel  input  SEL_W  channel select, used only when MODE=0.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- err_sel  output  1  sticky: an out-of-range select was applied.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ch=0, err_sel=0, round-robin pointer ptr=0. in_ready is all-zero during reset.
- Space signal: space = !out_valid || out_ready. This allows one transfer per cycle at full throughput.
- Grant, MODE=0:
  - cand = sel.
  - gnt_any = (sel < NUM_CH) && in_valid[sel].
  - gnt_idx = sel.
- Grant, MODE=1:
  - Scan channels ptr, ptr+1, ..., wrapping modulo NUM_CH.
  - gnt_idx = first channel with in_valid=1; gnt_any = |in_valid.
- Ready: in_ready[i] = gnt_any && space && (i == gnt_idx). At most one bit is set.
  - in_ready may depend combinationally on in_valid, sel and out_ready.
  - Producers must not make in_valid depend on in_ready.
- Load: load = gnt_any && space. On the clock edge with load=1:
  - out_data <= channel gnt_idx data.
  - out_ch <= gnt_idx.
  - out_valid <= 1.
- Drain: on an edge with out_valid && out_ready && !load, out_valid <= 0. out_data and out_ch keep their last values.
- Stall: while out_valid && !out_ready, out_data, out_ch and out_valid are held stable and all in_ready bits are 0.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle with out_ready held at 1.
- Pointer: in MODE=1 only, on load, ptr <= (gnt_idx == NUM_CH-1) ? 0 : gnt_idx+1. ptr is unchanged when there is no load. In MODE=0, ptr stays 0.
- Fairness (MODE=1): with all channels valid continuously and out_ready=1, grants are 0,1,...,NUM_CH-1,0,...
- Out-of-range select (MODE=0, sel >= NUM_CH):
  - No grant and no in_ready.
  - err_sel is set if any in_valid=1 in that cycle; err_sel is cleared only by reset.
  - The output register is never driven to X or Z.
- Select change while stalled: has no effect on the held output. The new sel applies at the next cycle where space=1.
- Simultaneous drain and load in the same cycle: the load wins, out_valid stays 1 and the new data replaces the old. The old word counts as consumed.
- Reset mid-stream: any held word is discarded. The first word after rst_n rises needs a fresh handshake.

Test Plan:
- Reset/idle: assert rst_n=0 with in_valid=4'hF. Required: out_valid=0, out_data=0, in_ready=0, err_sel=0. After release with in_valid=0, outputs stay 0.
- MODE=0 select: sel=2, in_data ch2=32'hDEADBEEF, in_valid=4'b0100, out_ready=1. Required: in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=32'hDEADBEEF, out_ch=2.
- Backpressure: load 32'h11111111 from ch0, then hold out_ready=0 for 3 cycles while ch1 presents 32'h22222222. Required: out_data stays 32'h11111111 and in_ready=0 throughout. One cycle after out_ready=1, out_data=32'h22222222.
- Round-robin (MODE=1, NUM_CH=4): all in_valid=1, ch i data = i+32'hA0, out_ready=1 for 6 cycles. Required: out_ch sequence 0,1,2,3,0,1 with out_data A0,A1,A2,A3,A0,A1. Next test: in_valid=4'b1010 with ptr=2 must grant ch3 first.
- Out-of-range (MODE=0, NUM_CH=3, SEL_W=2): sel=3, in_valid=3'b111. Required: in_ready=0, out_valid unchanged, err_sel=1 the next cycle and staying 1 after sel=0 is applied.
- Reset mid-operation: hold out_valid=1 with out_ready=0, then pulse rst_n low asynchronously between clock edges. Required: out_valid=0 immediately and ptr=0; the first post-reset grant in MODE=1 goes to ch0.
